// File: rtl/tx_fsrc_insert_invalid_if.sv
// Stream bundle for the FSRC invalid-sample inserter: sample input, hole mask
// input and beat output, each with its own valid/ready handshake.
interface tx_fsrc_insert_invalid_if #(
  parameter int DATA_WIDTH = 512,
  parameter int NP         = 16
);
  localparam int NUM_SAMPLES = DATA_WIDTH / NP;

  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_SAMPLES-1:0] holes_mask;
  logic                   holes_valid;
  logic                   holes_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;

  // Upstream / downstream environment side
  modport master (
    output in_data, in_valid, holes_mask, holes_valid, out_ready,
    input  in_ready, holes_ready, out_data, out_valid
  );

  // Inserter side
  modport slave (
    input  in_data, in_valid, holes_mask, holes_valid, out_ready,
    output in_ready, holes_ready, out_data, out_valid
  );
endinterface

// File: rtl/tx_fsrc_insert_invalid.sv
// TX-side FSRC invalid-sample inserter. Densely packed samples are buffered and
// spread over output beats; every lane flagged in the hole mask carries the
// invalid marker (MSB set, rest zero). With fsrc_en low the block is a
// combinational passthrough and its internal state is cleared.
module tx_fsrc_insert_invalid #(
  parameter int DATA_WIDTH = 512,
  parameter int NP         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fsrc_en,
  tx_fsrc_insert_invalid_if.slave  bus
);

  localparam int unsigned NUM_SAMPLES = DATA_WIDTH / NP;
  localparam int unsigned BUF_SAMPLES = 2 * NUM_SAMPLES;
  localparam int unsigned CNT_W       = $clog2(BUF_SAMPLES + 1);
  localparam int unsigned IDX_W       = $clog2(BUF_SAMPLES);
  localparam logic [NP-1:0] MARKER    = {1'b1, {(NP-1){1'b0}}};

  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      need_n, shift_n, base;
  logic [NP-1:0]         buf_q [BUF_SAMPLES];
  logic [NP-1:0]         buf_d [BUF_SAMPLES];
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, beat;
  logic                  out_valid_q, out_valid_d;
  logic                  room, load_ok, fire, acc;
  logic [IDX_W-1:0]      rd_idx;

  // Samples the current mask needs: one per non-hole lane
  always_comb begin
    need_n = '0;
    for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
      if (!bus.holes_mask[i]) need_n = need_n + CNT_W'(1);
    end
  end

  // Handshake decisions; a mask never waits on samples arriving this cycle
  always_comb begin
    room    = (count_q <= CNT_W'(NUM_SAMPLES));
    load_ok = ~out_valid_q | bus.out_ready;
    fire    = fsrc_en & ~reset & bus.holes_valid & load_ok & (count_q >= need_n);
    acc     = fsrc_en & room & bus.in_valid;
  end

  // Output mux: registered stream when enabled, straight wires in bypass
  always_comb begin
    if (fsrc_en) begin
      bus.in_ready    = room;
      bus.holes_ready = fire;
      bus.out_data    = out_data_q;
      bus.out_valid   = out_valid_q;
    end else begin
      bus.in_ready    = bus.out_ready;
      bus.holes_ready = 1'b0;
      bus.out_data    = bus.in_data;
      bus.out_valid   = bus.in_valid;
    end
  end

  // Beat assembly: non-hole lanes take buffered samples oldest-first
  always_comb begin
    beat   = '0;
    rd_idx = '0;
    for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
      if (bus.holes_mask[i]) begin
        beat[i*NP +: NP] = MARKER;
      end else begin
        beat[i*NP +: NP] = buf_q[rd_idx];
        rd_idx           = rd_idx + IDX_W'(1);
      end
    end
  end

  // Buffer update: drop consumed samples, then append the accepted beat
  // directly behind the survivors so both happen in one cycle
  always_comb begin
    shift_n = fire ? need_n : '0;
    base    = count_q - shift_n;
    for (int unsigned j = 0; j < BUF_SAMPLES; j++) begin
      if (j + 32'(shift_n) < BUF_SAMPLES) buf_d[j] = buf_q[IDX_W'(j + 32'(shift_n))];
      else                                buf_d[j] = '0;
      if (acc && (j >= 32'(base)) && (j < 32'(base) + NUM_SAMPLES))
        buf_d[j] = bus.in_data[(j - 32'(base))*NP +: NP];
    end
    if (!fsrc_en) count_d = '0;
    else          count_d = base + (acc ? CNT_W'(NUM_SAMPLES) : '0);
  end

  // Output register: load on fire, drain on ready, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!fsrc_en) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = beat;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Sample storage; contents are qualified by count_q so no reset needed
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_tx_fsrc_insert_invalid.sv
// Bench for tx_fsrc_insert_invalid (64-bit beats, 16-bit samples, 4 lanes).
// A queue-based reference model tracks buffered samples and the pending beat.
module tb_tx_fsrc_insert_invalid;
  localparam int DW = 64;
  localparam int NP = 16;
  localparam int NS = 4;
  localparam logic [15:0] MK = 16'h8000;

  logic clk = 1'b0;
  logic reset;
  logic fsrc_en;
  always #5 clk = ~clk;

  tx_fsrc_insert_invalid_if #(.DATA_WIDTH(DW), .NP(NP)) bus ();
  tx_fsrc_insert_invalid #(.DATA_WIDTH(DW), .NP(NP)) dut (
    .clk(clk), .reset(reset), .fsrc_en(fsrc_en), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] mq[$];
  logic        exp_ov = 1'b0;
  logic [63:0] exp_od = '0;
  logic [63:0] got[$];
  logic        saw_ir_low;

  task automatic cycle();
    int n;
    logic e_ir, e_hr, acc;
    logic [63:0] b;
    e_hr = 1'b0;
    b = '0;
    #1;
    n = 0;
    for (int i = 0; i < NS; i++) if (!bus.holes_mask[i]) n++;
    if (reset) begin
      checks++;
      if (bus.holes_ready !== 1'b0) begin errors++; $display("FAIL reset_holes_ready: got %b expected 0", bus.holes_ready); end
      mq.delete(); exp_ov = 1'b0; exp_od = '0;
    end else if (!fsrc_en) begin
      checks++;
      if (bus.in_ready !== bus.out_ready) begin errors++; $display("FAIL byp_in_ready: got %b expected %b", bus.in_ready, bus.out_ready); end
      checks++;
      if (bus.holes_ready !== 1'b0) begin errors++; $display("FAIL byp_holes_ready: got %b expected 0", bus.holes_ready); end
      checks++;
      if (bus.out_valid !== bus.in_valid) begin errors++; $display("FAIL byp_out_valid: got %b expected %b", bus.out_valid, bus.in_valid); end
      checks++;
      if (bus.out_data !== bus.in_data) begin errors++; $display("FAIL byp_out_data: got %h expected %h", bus.out_data, bus.in_data); end
      mq.delete(); exp_ov = 1'b0;
    end else begin
      e_ir = (mq.size() <= NS);
      e_hr = bus.holes_valid && (!exp_ov || bus.out_ready) && (mq.size() >= n);
      checks++;
      if (bus.in_ready !== e_ir) begin errors++; $display("FAIL in_ready: got %b expected %b (buffered %0d)", bus.in_ready, e_ir, mq.size()); end
      checks++;
      if (bus.holes_ready !== e_hr) begin errors++; $display("FAIL holes_ready: got %b expected %b", bus.holes_ready, e_hr); end
      if (!e_ir) saw_ir_low = 1'b1;
      acc = bus.in_valid && e_ir;
      if (e_hr) begin
        for (int i = 0; i < NS; i++) b[16*i +: 16] = bus.holes_mask[i] ? MK : mq.pop_front();
        exp_ov = 1'b1; exp_od = b;
      end else if (bus.out_ready) begin
        exp_ov = 1'b0;
      end
      if (acc) for (int i = 0; i < NS; i++) mq.push_back(bus.in_data[16*i +: 16]);
    end
    @(posedge clk); #1;
    if (reset) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++;
      if (bus.out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    end else if (fsrc_en) begin
      checks++;
      if (bus.out_valid !== exp_ov) begin errors++; $display("FAIL out_valid: got %b expected %b", bus.out_valid, exp_ov); end
      if (exp_ov) begin
        checks++;
        if (bus.out_data !== exp_od) begin errors++; $display("FAIL out_data: got %h expected %h", bus.out_data, exp_od); end
      end
      if (e_hr) got.push_back(bus.out_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fsrc_en = 1'b1;
    bus.in_valid = 1'b1; bus.holes_valid = 1'b1; bus.holes_mask = 4'b1111;
    bus.in_data = {$urandom, $urandom}; bus.out_ready = 1'b1;
    repeat (3) cycle();
    reset = 1'b0; bus.in_valid = 1'b0; bus.holes_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_passthrough();
    got.delete();
    bus.holes_mask = 4'b0000; bus.holes_valid = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 64'h0003_0002_0001_0000;
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pass_early_valid: got %b expected 0", bus.out_valid); end
    bus.in_data = 64'h0007_0006_0005_0004;
    cycle();
    checks++;
    if (bus.out_data !== 64'h0003_0002_0001_0000 || bus.out_valid !== 1'b1)
      begin errors++; $display("FAIL pass_beat0: got %b/%h expected 1/0003000200010000", bus.out_valid, bus.out_data); end
    bus.in_valid = 1'b0;
    cycle();
    checks++;
    if (bus.out_data !== 64'h0007_0006_0005_0004 || bus.out_valid !== 1'b1)
      begin errors++; $display("FAIL pass_beat1: got %b/%h expected 1/0007000600050004", bus.out_valid, bus.out_data); end
    bus.holes_valid = 1'b0;
    cycle();
  endtask

  task automatic test_single_hole();
    logic [63:0] exp3 [3];
    int s;
    logic a;
    exp3[0] = 64'h0002_0001_0000_8000;
    exp3[1] = 64'h0005_0004_0003_8000;
    exp3[2] = 64'h0008_0007_0006_8000;
    got.delete(); saw_ir_low = 1'b0; s = 0;
    bus.holes_mask = 4'b0001; bus.holes_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (10) begin
      bus.in_valid = (s < 12);
      bus.in_data  = {16'(s+3), 16'(s+2), 16'(s+1), 16'(s)};
      a = bus.in_valid && (mq.size() <= NS);
      cycle();
      if (a) s += 4;
    end
    bus.in_valid = 1'b0; bus.holes_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL hole1_beat%0d: got none expected %h", i, exp3[i]); end
      else if (got[i] !== exp3[i]) begin errors++; $display("FAIL hole1_beat%0d: got %h expected %h", i, got[i], exp3[i]); end
    end
    checks++;
    if (saw_ir_low !== 1'b1) begin errors++; $display("FAIL hole1_in_ready_low: got %b expected 1", saw_ir_low); end
  endtask

  task automatic test_edge_masks();
    got.delete();
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    bus.holes_mask = 4'b1111; bus.holes_valid = 1'b1;
    cycle();
    bus.holes_mask = 4'b1010; bus.in_valid = 1'b1; bus.in_data = 64'h0003_0002_0001_0000;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.holes_mask = 4'b0011;
    cycle();
    bus.holes_valid = 1'b0;
    cycle();
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL edge_beat_count: got %0d expected 3", got.size()); end
    else begin
      checks++;
      if (got[0] !== 64'h8000_8000_8000_8000) begin errors++; $display("FAIL edge_all_holes: got %h expected 8000800080008000", got[0]); end
      checks++;
      if (got[1] !== 64'h8000_0001_8000_0000) begin errors++; $display("FAIL edge_1010: got %h expected 8000000180000000", got[1]); end
      checks++;
      if (got[2] !== 64'h0003_0002_8000_8000) begin errors++; $display("FAIL edge_leftover: got %h expected 0003000280008000", got[2]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] snap;
    for (int k = 0; k < 60; k++) begin
      bus.in_valid    = $urandom_range(0, 1);
      bus.in_data     = {$urandom, $urandom} & 64'h7fff_7fff_7fff_7fff;
      bus.holes_valid = $urandom_range(0, 1);
      bus.holes_mask  = 4'($urandom);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      if (k == 19) begin bus.holes_valid = 1'b1; bus.holes_mask = 4'b1111; bus.out_ready = 1'b1; end
      if (k >= 20 && k < 25) begin bus.out_ready = 1'b0; bus.holes_valid = 1'b1; end
      if (k == 20) snap = bus.out_data;
      cycle();
      if (k >= 20 && k < 25) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b expected 1", k, bus.out_valid); end
        checks++;
        if (bus.out_data !== snap) begin errors++; $display("FAIL stall_data_%0d: got %h expected %h", k, bus.out_data, snap); end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.holes_valid = 1'b1; bus.holes_mask = 4'b0000;
    repeat (4) cycle();
    bus.holes_valid = 1'b0;
    cycle();
  endtask

  task automatic test_bypass();
    fsrc_en = 1'b0;
    repeat (10) begin
      bus.in_valid    = $urandom_range(0, 1);
      bus.in_data     = {$urandom, $urandom};
      bus.holes_valid = $urandom_range(0, 1);
      bus.holes_mask  = 4'($urandom);
      bus.out_ready   = $urandom_range(0, 1);
      cycle();
    end
    bus.in_valid = 1'b0; bus.holes_valid = 1'b0; bus.out_ready = 1'b1;
    cycle();
    fsrc_en = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    got.delete();
    bus.out_ready = 1'b1;
    bus.holes_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 64'h0013_0012_0011_0010;
    cycle();
    bus.holes_valid = 1'b1; bus.holes_mask = 4'b0011; bus.in_data = 64'h0017_0016_0015_0014;
    cycle();
    bus.in_valid = 1'b0; bus.holes_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL six_buffered_in_ready: got %b expected 0", bus.in_ready); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    got.delete();
    bus.holes_mask = 4'b1111; bus.holes_valid = 1'b1;
    cycle();
    bus.holes_valid = 1'b0;
    checks++;
    if (got.size() != 1 || bus.out_data !== 64'h8000_8000_8000_8000)
      begin errors++; $display("FAIL post_reset_fire: got %0d beats data %h expected 1 beat 8000800080008000", got.size(), bus.out_data); end
    cycle();
  endtask

  initial begin
    reset = 1'b1; fsrc_en = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.holes_valid = 1'b0;
    bus.holes_mask = '0; bus.out_ready = 1'b1;
    test_reset();
    test_passthrough();
    test_single_hole();
    test_edge_masks();
    test_back_pressure();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
